fp_addsub_seq: RTL and testbench

Multi-cycle sequencer for single-precision (IEEE-754 binary32) add/subtract. It captures two operands over a valid/ready handshake and aligns the smaller-exponent mantissa serially, one bit per cycle. It then performs one magnitude add/subtract, normalizes iteratively and presents the result over a valid/ready output handshake. It sits above the exponent-compare/fraction-alignment datapath and owns its sequencing.

---
 rtl/fp_addsub_seq.sv | 232 +++++++++++++++++++++++
 tb/tb_fp_addsub_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_seq.sv
// -----------------------------------------------------------------------------
// fp_addsub_seq
// Multi-cycle binary32 add/subtract sequencer. Operands are taken over a
// valid/ready handshake. The smaller-magnitude mantissa is aligned one bit per
// cycle, a single magnitude add/subtract is done, and the sum is normalized one
// step per cycle. The result is then offered over a valid/ready handshake.
// Denormal inputs and underflowing results are flushed to zero. Rounding is
// truncation.
//
// Optional build macro:
//   FPAU_SPECIAL_EN - when defined, an operand with exponent 8'hFF skips the
//                     arithmetic. NaN, or inf-inf under effective subtraction,
//                     gives 32'h7FC00000. Otherwise the result is the signed
//                     infinity.
//
// Ports:
//   clk        system clock, rising edge
//   rstn       asynchronous active-low reset
//   in_valid   operands valid
//   in_ready   block can accept operands (state is IDLE)
//   a, b       binary32 operands
//   op         0 = A+B, 1 = A-B
//   out_valid  result valid
//   out_ready  consumer accepts result
//   result     binary32 result, held stable while out_valid && !out_ready
//   busy       high in every state except IDLE
// -----------------------------------------------------------------------------
module fp_addsub_seq #(
  parameter int unsigned ALIGN_LIMIT = 25
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_ADD   = 3'd2,
    ST_NORM  = 3'd3,
    ST_DONE  = 3'd4,
    ST_SPEC  = 3'd5
  } state_t;

  state_t      state_r, state_nx;
  logic        sign_r, sign_nx;        // sign of the larger operand
  logic        eff_sub_r, eff_sub_nx;  // operand signs differ: magnitude subtract
  logic [7:0]  exp_r, exp_nx;
  logic [23:0] mant_l_r, mant_l_nx;
  logic [23:0] mant_s_r, mant_s_nx;
  logic [7:0]  diff_r, diff_nx;
  logic [24:0] sum_r, sum_nx;
  logic [31:0] result_r, result_nx;
  logic        out_valid_r, out_valid_nx;

  logic [7:0]  exp_a_s, exp_b_s, diff_raw_s;
  logic [23:0] man_a_s, man_b_s;
  logic        sign_b_eff_s, a_large_s;
  logic [8:0]  exp_inc_s;
`ifdef FPAU_SPECIAL_EN
  logic        special_s;
  logic [31:0] spec_result_s;
`endif

  // Operand decode: flush-to-zero, effective sign of B, magnitude compare.
  always_comb begin
    exp_a_s      = a[30:23];
    exp_b_s      = b[30:23];
    man_a_s      = (exp_a_s == 8'd0) ? 24'd0 : {1'b1, a[22:0]};
    man_b_s      = (exp_b_s == 8'd0) ? 24'd0 : {1'b1, b[22:0]};
    sign_b_eff_s = b[31] ^ op;
    // Ties on exponent and mantissa keep A as the larger operand.
    a_large_s    = (exp_a_s > exp_b_s) ||
                   ((exp_a_s == exp_b_s) && (man_a_s >= man_b_s));
    diff_raw_s   = a_large_s ? (exp_a_s - exp_b_s) : (exp_b_s - exp_a_s);
    exp_inc_s    = {1'b0, exp_r} + 9'd1;
`ifdef FPAU_SPECIAL_EN
    special_s = (exp_a_s == 8'hFF) || (exp_b_s == 8'hFF);
    if (((exp_a_s == 8'hFF) && (a[22:0] != 23'd0)) ||
        ((exp_b_s == 8'hFF) && (b[22:0] != 23'd0)) ||
        ((exp_a_s == 8'hFF) && (exp_b_s == 8'hFF) && (a[31] != sign_b_eff_s))) begin
      spec_result_s = 32'h7FC00000;
    end else if (exp_a_s == 8'hFF) begin
      spec_result_s = {a[31], 8'hFF, 23'd0};
    end else begin
      spec_result_s = {sign_b_eff_s, 8'hFF, 23'd0};
    end
`endif
  end

  // Next-state and datapath update for the sequencer.
  always_comb begin
    state_nx   = state_r;
    sign_nx    = sign_r;
    eff_sub_nx = eff_sub_r;
    exp_nx     = exp_r;
    mant_l_nx  = mant_l_r;
    mant_s_nx  = mant_s_r;
    diff_nx    = diff_r;
    sum_nx     = sum_r;
    result_nx  = result_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          sign_nx    = a_large_s ? a[31] : sign_b_eff_s;
          eff_sub_nx = a[31] ^ sign_b_eff_s;
          exp_nx     = a_large_s ? exp_a_s : exp_b_s;
          mant_l_nx  = a_large_s ? man_a_s : man_b_s;
          // Far-apart exponents: the small operand vanishes entirely, so
          // skip the serial shifts.
          if (32'(diff_raw_s) >= ALIGN_LIMIT) begin
            mant_s_nx = 24'd0;
            diff_nx   = 8'd0;
          end else begin
            mant_s_nx = a_large_s ? man_b_s : man_a_s;
            diff_nx   = diff_raw_s;
          end
`ifdef FPAU_SPECIAL_EN
          if (special_s) begin
            result_nx = spec_result_s;
            state_nx  = ST_SPEC;
          end else begin
            state_nx  = ST_ALIGN;
          end
`else
          state_nx = ST_ALIGN;
`endif
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_ALIGN: begin
        if (diff_r == 8'd0) begin
          state_nx = ST_ADD;
        end else begin
          mant_s_nx = {1'b0, mant_s_r[23:1]};
          diff_nx   = diff_r - 8'd1;
        end
      end
      ST_ADD: begin
        // The larger magnitude is always mant_l, so the difference is never negative.
        if (eff_sub_r) begin
          sum_nx = {1'b0, mant_l_r} - {1'b0, mant_s_r};
        end else begin
          sum_nx = {1'b0, mant_l_r} + {1'b0, mant_s_r};
        end
        state_nx = ST_NORM;
      end
      ST_NORM: begin
        if (sum_r == 25'd0) begin
          result_nx = 32'h00000000;
          state_nx  = ST_DONE;
        end else if (sum_r[24]) begin
          sum_nx = {1'b0, sum_r[24:1]};
          exp_nx = exp_inc_s[7:0];
          if (exp_inc_s >= 9'd255) begin
            result_nx = {sign_r, 8'hFF, 23'd0};
          end else begin
            result_nx = {sign_r, exp_inc_s[7:0], sum_r[23:1]};
          end
          state_nx = ST_DONE;
        end else if (sum_r[23]) begin
          result_nx = {sign_r, exp_r, sum_r[22:0]};
          state_nx  = ST_DONE;
        end else if (exp_r == 8'd1) begin
          // Underflow: flushed results are always +0.
          result_nx = 32'h00000000;
          state_nx  = ST_DONE;
        end else begin
          sum_nx = {sum_r[23:0], 1'b0};
          exp_nx = exp_r - 8'd1;
        end
      end
      ST_DONE: begin
        if (out_valid_r && out_ready) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_DONE;
        end
      end
      ST_SPEC: begin
        state_nx = ST_DONE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
    // out_valid rises one cycle after DONE is entered and drops on transfer.
    out_valid_nx = (state_r == ST_DONE) && !(out_valid_r && out_ready);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= ST_IDLE;
      sign_r      <= 1'b0;
      eff_sub_r   <= 1'b0;
      exp_r       <= 8'd0;
      mant_l_r    <= 24'd0;
      mant_s_r    <= 24'd0;
      diff_r      <= 8'd0;
      sum_r       <= 25'd0;
      result_r    <= 32'd0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nx;
      sign_r      <= sign_nx;
      eff_sub_r   <= eff_sub_nx;
      exp_r       <= exp_nx;
      mant_l_r    <= mant_l_nx;
      mant_s_r    <= mant_s_nx;
      diff_r      <= diff_nx;
      sum_r       <= sum_nx;
      result_r    <= result_nx;
      out_valid_r <= out_valid_nx;
    end
  end

  assign in_ready  = (state_r == ST_IDLE);
  assign busy      = (state_r != ST_IDLE);
  assign out_valid = out_valid_r;
  assign result    = result_r;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Self-checking bench for fp_addsub_seq: directed cases plus random operands
// compared against an arithmetic reference model (result and latency).
module tb_fp_addsub_seq;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        op = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        busy;

  int checks = 0;
  int errors = 0;

  fp_addsub_seq dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: value-level add/sub with truncation and flush-to-zero; latency
  // is 4 cycles plus one per alignment shift and per left-normalize step.
  task automatic ref_op(input logic [31:0] x, input logic [31:0] y, input logic o,
                        output logic [31:0] r, output int lat);
    int ex, ey, el, es, d, e;
    logic [31:0] mx, my, ml, ms, s;
    logic sx, sy, sl, ss, x_big, flushed;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    mx = (ex == 0) ? 32'd0 : ({9'd0, x[22:0]} + 32'h0080_0000);
    my = (ey == 0) ? 32'd0 : ({9'd0, y[22:0]} + 32'h0080_0000);
    sx = x[31];
    sy = y[31] ^ o;
    x_big = (ex > ey) || ((ex == ey) && (mx >= my));
    el = x_big ? ex : ey;  es = x_big ? ey : ex;
    ml = x_big ? mx : my;  ms = x_big ? my : mx;
    sl = x_big ? sx : sy;  ss = x_big ? sy : sx;
    d = el - es;
    lat = 4;
    if (d >= 25) begin
      ms = 32'd0;
    end else begin
      ms = ms >> d;
      lat = lat + d;
    end
    s = (sl == ss) ? (ml + ms) : (ml - ms);
    e = el;
    flushed = 1'b0;
    if (s == 32'd0) begin
      r = 32'd0;
    end else if (s >= 32'h0100_0000) begin
      e = e + 1;
      if (e >= 255) r = {sl, 8'hFF, 23'd0};
      else r = {sl, 8'(e), s[23:1]};
    end else begin
      while (s < 32'h0080_0000 && !flushed) begin
        if (e == 1) begin
          flushed = 1'b1;
        end else begin
          s = s << 1;
          e = e - 1;
          lat = lat + 1;
        end
      end
      r = flushed ? 32'd0 : {sl, 8'(e), s[22:0]};
    end
  endtask

  // One complete transaction with out_ready high: checks result, latency,
  // in_ready low while working, and the output transfer.
  task automatic do_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                       input logic o, input logic [31:0] exp_res, input int exp_lat);
    int n, lat, rdy_seen;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_in_ready_before"}, 32'(in_ready), 32'd1);
    a = x; b = y; op = o; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; op = 1'($urandom);
    lat = 0;
    rdy_seen = 0;
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_seen++;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_in_ready_while_busy"}, 32'(rdy_seen), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_out_valid_after_xfer"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready_after_xfer"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] held, rr, x, y;
    int rl, ea, eb, k, n;
    logic o;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", result, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Directed cases
    do_op("one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4);
    do_op("three_minus_one", 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 5);
    do_op("one_minus_one", 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4);
    do_op("far_diff", 32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 4);
    do_op("overflow_inf", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4);
    do_op("cancel_23", 32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 27);
    do_op("denorm_flush", 32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 4);
    do_op("underflow_flush", 32'h00C00000, 32'h00800001, 1'b1, 32'h00000000, 4);

    // Back-pressure: result held while out_ready is low, new operands ignored
    @(negedge clk);
    out_ready = 1'b0;
    a = 32'h3F800000; b = 32'h3F800000; op = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 32'h40400000; b = 32'h40400000;  // stays valid, must be ignored
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    held = result;
    chk("hold_result", held, 32'h40000000);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_stable", result, held);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_xfer_out_valid", 32'(out_valid), 32'd0);
    chk("hold_xfer_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("hold_no_ghost_busy", 32'(busy), 32'd0);

    // Reset in the middle of alignment (exponent difference 20)
    @(negedge clk);
    a = 32'h3F800000; b = 32'h35800000; op = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_busy_before", 32'(busy), 32'd1);
    rstn = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid) n++;
    end
    chk("midrst_no_output", 32'(n), 32'd0);
    do_op("after_rst", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4);

`ifdef FPAU_SPECIAL_EN
    do_op("inf_minus_inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 2);
    do_op("inf_plus_one", 32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 2);
`endif

    // Random operands against the reference model
    for (int t = 0; t < 60; t++) begin
      ea = $urandom_range(1, 254);
      if ($urandom_range(0, 9) == 0) ea = 0;
      k = $urandom_range(0, 3);
      if (k == 0) eb = ea;
      else if (k == 1) eb = ea + $urandom_range(0, 6) - 3;
      else eb = $urandom_range(1, 254);
      if (eb < 1) eb = 1;
      if (eb > 254) eb = 254;
      x = {1'($urandom), 8'(ea), 23'($urandom)};
      y = {1'($urandom), 8'(eb), 23'($urandom)};
      if (k == 3) y = {y[31], x[30:23], x[22:0] ^ (23'd1 << $urandom_range(0, 22))};
      o = 1'($urandom);
      ref_op(x, y, o, rr, rl);
      do_op("random", x, y, o, rr, rl);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
